// File: rtl/aes128_mmio_host.sv
// MMIO command host: turns single read/write commands into CCI-P style MMIO
// requests, matches read responses by tid, and reports data, timeouts and
// rejected (misaligned) commands.

package ccip_if_pkg;

    typedef struct packed {
        logic [15:0] address;
        logic [1:0]  length;
        logic        rsvd;
        logic [8:0]  tid;
    } t_ccip_c0_ReqMmioHdr;

    typedef struct packed {
        t_ccip_c0_ReqMmioHdr hdr;
        logic [63:0]         data;
        logic                rspValid;
        logic                mmioRdValid;
        logic                mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        logic [8:0] tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr hdr;
        logic                mmioRdValid;
        logic [63:0]         data;
    } t_if_ccip_c2_Tx;

endpackage

module aes128_mmio_host
    import ccip_if_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 512
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic           cmd_write,
    input  logic [15:0]    cmd_addr,
    input  logic [63:0]    cmd_data,
    output t_if_ccip_c0_Rx rx_mmio_channel,
    input  t_if_ccip_c2_Tx tx_mmio_channel,
    output logic           rsp_valid,
    output logic [63:0]    rsp_data,
    output logic           rsp_timeout,
    output logic           rsp_error,
    output logic [15:0]    stat_stray,
    output logic [15:0]    stat_timeouts
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e         state_q;
    logic [8:0]     cur_tid_q;
    logic [15:0]    timer_q;
    t_if_ccip_c0_Rx rx_q;
    logic           rsp_valid_q;
    logic [63:0]    rsp_data_q;
    logic           rsp_timeout_q;
    logic           rsp_error_q;
    logic [15:0]    stray_q;
    logic [15:0]    timeouts_q;

    logic rsp_match;
    logic expired;
    logic stray;

    // Response matching: rx_q.hdr.tid still holds the tid of the outstanding read.
    always_comb begin
        rsp_match = (state_q == StWait) && tx_mmio_channel.mmioRdValid &&
                    (tx_mmio_channel.hdr.tid == rx_q.hdr.tid);
        expired   = (state_q == StWait) && (timer_q == 16'(TIMEOUT_CYCLES - 1));
        stray     = tx_mmio_channel.mmioRdValid && !rsp_match;
    end

    // Command FSM with registered request, response and statistics outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            cur_tid_q     <= '0;
            timer_q       <= '0;
            rx_q          <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b0;
            rsp_error_q   <= 1'b0;
            stray_q       <= '0;
            timeouts_q    <= '0;
        end else begin
            if (stray && (stray_q != 16'hFFFF)) begin
                stray_q <= stray_q + 16'd1;
            end
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        if (cmd_addr[0]) begin
                            // Misaligned: reject without touching the bus.
                            state_q       <= StDone;
                            rsp_valid_q   <= 1'b1;
                            rsp_error_q   <= 1'b1;
                            rsp_timeout_q <= 1'b0;
                            rsp_data_q    <= '0;
                        end else begin
                            state_q              <= StIssue;
                            rx_q.hdr.address     <= cmd_addr;
                            rx_q.hdr.length      <= 2'b01;
                            rx_q.hdr.rsvd        <= 1'b0;
                            rx_q.hdr.tid         <= cmd_write ? 9'd0 : cur_tid_q;
                            rx_q.data            <= cmd_data;
                            rx_q.mmioWrValid     <= cmd_write;
                            rx_q.mmioRdValid     <= !cmd_write;
                        end
                    end
                end
                StIssue: begin
                    rx_q.mmioWrValid <= 1'b0;
                    rx_q.mmioRdValid <= 1'b0;
                    if (rx_q.mmioRdValid) begin
                        cur_tid_q <= cur_tid_q + 9'd1;
                        timer_q   <= '0;
                        state_q   <= StWait;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StWait: begin
                    timer_q <= timer_q + 16'd1;
                    // A match in the expiry cycle still wins.
                    if (rsp_match) begin
                        state_q       <= StDone;
                        rsp_valid_q   <= 1'b1;
                        rsp_data_q    <= tx_mmio_channel.data;
                        rsp_timeout_q <= 1'b0;
                        rsp_error_q   <= 1'b0;
                    end else if (expired) begin
                        state_q       <= StDone;
                        rsp_valid_q   <= 1'b1;
                        rsp_data_q    <= '0;
                        rsp_timeout_q <= 1'b1;
                        rsp_error_q   <= 1'b0;
                        if (timeouts_q != 16'hFFFF) begin
                            timeouts_q <= timeouts_q + 16'd1;
                        end
                    end
                end
                StDone: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cmd_ready       = (state_q == StIdle);
    assign rx_mmio_channel = rx_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_data        = rsp_data_q;
    assign rsp_timeout     = rsp_timeout_q;
    assign rsp_error       = rsp_error_q;
    assign stat_stray      = stray_q;
    assign stat_timeouts   = timeouts_q;

endmodule

// File: tb/tb_aes128_mmio_host.sv
// Self-checking bench for aes128_mmio_host: directed and randomized commands
// against a transaction-level model of the expected outcome of each command.

module tb_aes128_mmio_host;
    import ccip_if_pkg::*;

    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic           cmd_write = 1'b0;
    logic [15:0]    cmd_addr = '0;
    logic [63:0]    cmd_data = '0;
    t_if_ccip_c0_Rx rx;
    t_if_ccip_c2_Tx tx;
    logic           rsp_valid;
    logic [63:0]    rsp_data;
    logic           rsp_timeout;
    logic           rsp_error;
    logic [15:0]    stat_stray;
    logic [15:0]    stat_timeouts;

    aes128_mmio_host #(.TIMEOUT_CYCLES(TO)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_write       (cmd_write),
        .cmd_addr        (cmd_addr),
        .cmd_data        (cmd_data),
        .rx_mmio_channel (rx),
        .tx_mmio_channel (tx),
        .rsp_valid       (rsp_valid),
        .rsp_data        (rsp_data),
        .rsp_timeout     (rsp_timeout),
        .rsp_error       (rsp_error),
        .stat_stray      (stat_stray),
        .stat_timeouts   (stat_timeouts)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model state
    int          exp_tid = 0;
    int          exp_stray = 0;
    int          exp_timeouts = 0;
    logic [63:0] last_data = '0;
    logic        last_to = 1'b0;
    logic        last_err = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_stats(input string tag);
        check_eq({tag, "_stray"}, 64'(stat_stray), 64'(exp_stray));
        check_eq({tag, "_timeouts"}, 64'(stat_timeouts), 64'(exp_timeouts));
    endtask

    task automatic check_held(input string tag);
        check_eq({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check_eq({tag, "_ready"}, 64'(cmd_ready), 64'd1);
        check_eq({tag, "_data_hold"}, rsp_data, last_data);
        check_eq({tag, "_to_hold"}, 64'(rsp_timeout), 64'(last_to));
        check_eq({tag, "_err_hold"}, 64'(rsp_error), 64'(last_err));
    endtask

    task automatic do_write(input logic [15:0] a, input logic [63:0] d);
        check_eq("wr_ready", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_data = d;
        step();
        cmd_valid = 1'b0;
        check_eq("wr_valid", 64'(rx.mmioWrValid), 64'd1);
        check_eq("wr_rdvalid", 64'(rx.mmioRdValid), 64'd0);
        check_eq("wr_addr", 64'(rx.hdr.address), 64'(a));
        check_eq("wr_len", 64'(rx.hdr.length), 64'd1);
        check_eq("wr_tid", 64'(rx.hdr.tid), 64'd0);
        check_eq("wr_data", rx.data, d);
        check_eq("wr_busy", 64'(cmd_ready), 64'd0);
        check_eq("wr_no_rsp", 64'(rsp_valid), 64'd0);
        step();
        check_eq("wr_valid_off", 64'(rx.mmioWrValid), 64'd0);
        check_held("wr_end");
    endtask

    // delay: WAIT cycle index carrying the matching reply (>= TO means silent).
    // wrong_at: WAIT cycle index carrying a reply with another tid (-1 = none).
    task automatic do_read(input logic [15:0] a, input int delay, input int wrong_at,
                           input logic [63:0] d);
        int  tid = exp_tid;
        bit  matched = (delay < TO);
        int  exp_wait = matched ? delay + 1 : TO;
        int  waited = 0;
        bit  seen = 1'b0;
        int  wt;
        check_eq("rd_ready", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; cmd_data = $urandom;
        step();
        cmd_valid = 1'b0;
        check_eq("rd_valid", 64'(rx.mmioRdValid), 64'd1);
        check_eq("rd_wrvalid", 64'(rx.mmioWrValid), 64'd0);
        check_eq("rd_addr", 64'(rx.hdr.address), 64'(a));
        check_eq("rd_len", 64'(rx.hdr.length), 64'd1);
        check_eq("rd_tid", 64'(rx.hdr.tid), 64'(tid));
        step();
        check_eq("rd_valid_off", 64'(rx.mmioRdValid), 64'd0);
        check_eq("rd_busy", 64'(cmd_ready), 64'd0);
        for (int i = 0; i < TO + 4 && !seen; i++) begin
            tx = '0;
            if (i == delay) begin
                tx.mmioRdValid = 1'b1;
                tx.hdr.tid = 9'(tid);
                tx.data = d;
            end else if (i == wrong_at) begin
                wt = (tid + 1 + int'($urandom_range(0, 509))) % 512;
                tx.mmioRdValid = 1'b1;
                tx.hdr.tid = 9'(wt);
                tx.data = ~d;
                exp_stray++;
            end
            step();
            waited++;
            if (rsp_valid === 1'b1) seen = 1'b1;
        end
        tx = '0;
        if (!matched) exp_timeouts++;
        exp_tid = (exp_tid + 1) % 512;
        last_data = matched ? d : 64'd0;
        last_to = !matched;
        last_err = 1'b0;
        check_eq("rd_rsp_seen", 64'(seen), 64'd1);
        check_eq("rd_latency", 64'(waited), 64'(exp_wait));
        check_eq("rd_data", rsp_data, last_data);
        check_eq("rd_timeout", 64'(rsp_timeout), 64'(last_to));
        check_eq("rd_error", 64'(rsp_error), 64'd0);
        check_stats("rd");
        step();
        check_held("rd_end");
    endtask

    task automatic do_misaligned(input logic wr, input logic [15:0] a);
        check_eq("mis_ready", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_data = {$urandom, $urandom};
        step();
        cmd_valid = 1'b0;
        last_data = '0; last_to = 1'b0; last_err = 1'b1;
        check_eq("mis_rsp_valid", 64'(rsp_valid), 64'd1);
        check_eq("mis_error", 64'(rsp_error), 64'd1);
        check_eq("mis_data", rsp_data, 64'd0);
        check_eq("mis_timeout", 64'(rsp_timeout), 64'd0);
        check_eq("mis_rdvalid", 64'(rx.mmioRdValid), 64'd0);
        check_eq("mis_wrvalid", 64'(rx.mmioWrValid), 64'd0);
        step();
        check_held("mis_end");
    endtask

    task automatic stray_reply(input int tid);
        tx = '0;
        tx.mmioRdValid = 1'b1;
        tx.hdr.tid = 9'(tid);
        tx.data = {$urandom, $urandom};
        step();
        tx = '0;
        exp_stray++;
        check_stats("stray");
        check_held("stray_end");
    endtask

    function automatic logic [15:0] rand_even();
        logic [15:0] a;
        a = 16'($urandom_range(0, 65535));
        a[0] = 1'b0;
        return a;
    endfunction

    initial begin
        int old_tid;
        int delay;
        int lim;
        int wrong_at;
        tx = '0;

        // Reset state
        step();
        check_eq("rst_ready", 64'(cmd_ready), 64'd1);
        check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("rst_rsp_data", rsp_data, 64'd0);
        check_eq("rst_rx_hdr", 64'(rx.hdr), 64'd0);
        check_eq("rst_rx_data", rx.data, 64'd0);
        check_eq("rst_rx_valids", 64'({rx.rspValid, rx.mmioRdValid, rx.mmioWrValid}), 64'd0);
        check_stats("rst");
        @(negedge clk);
        reset_n = 1'b1;
        step();
        check_eq("post_rst_ready", 64'(cmd_ready), 64'd1);

        // Directed cases
        do_write(16'h000A, 64'h1234);
        do_read(16'h0002, 4, -1, 64'hC000C9660D824272);
        do_read(rand_even(), 0, -1, {$urandom, $urandom});
        old_tid = exp_tid;
        do_read(rand_even(), TO + 5, -1, {$urandom, $urandom});
        stray_reply(old_tid);
        do_read(rand_even(), 6, 2, {$urandom, $urandom});
        do_read(rand_even(), TO - 1, -1, {$urandom, $urandom});
        do_misaligned(1'b0, 16'h0003);
        do_read(rand_even(), 1, -1, {$urandom, $urandom});
        do_misaligned(1'b1, 16'hFFFF);

        // Randomized mix
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 5))
                0: do_write(rand_even(), {$urandom, $urandom});
                1: do_misaligned(1'($urandom_range(0, 1)), rand_even() | 16'd1);
                2: stray_reply(int'($urandom_range(0, 511)));
                default: begin
                    delay = int'($urandom_range(0, TO + 2));
                    lim = (delay < TO - 1) ? delay : TO - 1;
                    wrong_at = -1;
                    if (lim > 0 && $urandom_range(0, 1) == 1)
                        wrong_at = int'($urandom_range(0, lim - 1));
                    do_read(rand_even(), delay, wrong_at, {$urandom, $urandom});
                end
            endcase
        end

        // Back-to-back reads: tid wraps 511 -> 0
        for (int n = 0; n < 512; n++) begin
            do_read(rand_even(), int'($urandom_range(0, 2)), -1, {$urandom, $urandom});
        end

        // Reset in the middle of WAIT
        old_tid = exp_tid;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = rand_even();
        step();
        cmd_valid = 1'b0;
        step();
        step();
        reset_n = 1'b0;
        #1;
        exp_tid = 0; exp_stray = 0; exp_timeouts = 0;
        last_data = '0; last_to = 1'b0; last_err = 1'b0;
        check_eq("mid_rst_ready", 64'(cmd_ready), 64'd1);
        check_eq("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("mid_rst_rsp_data", rsp_data, 64'd0);
        check_eq("mid_rst_flags", 64'({rsp_timeout, rsp_error}), 64'd0);
        check_eq("mid_rst_rx_hdr", 64'(rx.hdr), 64'd0);
        check_eq("mid_rst_rx_data", rx.data, 64'd0);
        check_eq("mid_rst_rx_valids", 64'({rx.rspValid, rx.mmioRdValid, rx.mmioWrValid}), 64'd0);
        check_stats("mid_rst");
        @(negedge clk);
        reset_n = 1'b1;
        step();
        check_eq("mid_rst_ready_after", 64'(cmd_ready), 64'd1);
        stray_reply(old_tid);
        do_read(rand_even(), 1, -1, {$urandom, $urandom});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
